// File: rtl/reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bus_arbiter
//
// Two-master arbiter/sequencer for the shared register-bank bus. Requester 0
// (UART packet controller) and requester 1 (local on-chip master) each issue
// single read or write transactions; one transaction is in flight at a time
// and contention is resolved round-robin.
//
// Parameters
//   ADDR_W      register address width
//   DATA_W      register data width
//   RD_LATENCY  cycles from opAddress valid to ipRdData valid (1..15)
//
// Ports
//   ipClk, ipReset             clock, synchronous active-high reset
//   ipReq0/1                   level request from requester 0/1
//   ipWrite0/1                 1 = write, 0 = read
//   ipAddr0/1, ipWrData0/1     transaction address / write data
//   opAck0/1                   one-cycle completion pulse
//   opRdData0/1                read data, valid with the matching ack
//   opAddress, opWrData        register block address / write data
//   opWrEnable                 one-cycle write strobe to the register block
//   ipRdData                   read data from the register block
//   opBusy                     a transaction is in progress
//
// Every output is a register: the combinational process computes the next
// value of each output, the sequential process loads it.
// -----------------------------------------------------------------------------
module reg_bus_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              ipClk,
    input  logic              ipReset,

    input  logic              ipReq0,
    input  logic              ipWrite0,
    input  logic [ADDR_W-1:0] ipAddr0,
    input  logic [DATA_W-1:0] ipWrData0,
    output logic              opAck0,
    output logic [DATA_W-1:0] opRdData0,

    input  logic              ipReq1,
    input  logic              ipWrite1,
    input  logic [ADDR_W-1:0] ipAddr1,
    input  logic [DATA_W-1:0] ipWrData1,
    output logic              opAck1,
    output logic [DATA_W-1:0] opRdData1,

    output logic [ADDR_W-1:0] opAddress,
    output logic [DATA_W-1:0] opWrData,
    output logic              opWrEnable,
    input  logic [DATA_W-1:0] ipRdData,
    output logic              opBusy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ACK   = 2'd3
    } state_t;

    // Counter value on which the read data is captured; a 4-bit counter
    // covers the full RD_LATENCY range.
    localparam logic [3:0] LAST_CNT = 4'(RD_LATENCY - 1);

    state_t            state;
    state_t            stateNxt;
    logic              owner;          // requester of the transaction in flight
    logic              ownerNxt;
    logic              lastServed;     // requester that completed most recently
    logic              lastServedNxt;
    logic [3:0]        rdCnt;
    logic [3:0]        rdCntNxt;

    logic [ADDR_W-1:0] addressNxt;
    logic [DATA_W-1:0] wrDataNxt;
    logic              wrEnableNxt;
    logic              ack0Nxt;
    logic              ack1Nxt;
    logic [DATA_W-1:0] rdData0Nxt;
    logic [DATA_W-1:0] rdData1Nxt;
    logic              busyNxt;

    logic              grantOne;       // grant goes to requester 1
    logic              grantWrite;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        stateNxt      = state;
        ownerNxt      = owner;
        lastServedNxt = lastServed;
        rdCntNxt      = rdCnt;
        addressNxt    = opAddress;
        wrDataNxt     = opWrData;
        wrEnableNxt   = 1'b0;
        ack0Nxt       = 1'b0;
        ack1Nxt       = 1'b0;
        rdData0Nxt    = opRdData0;
        rdData1Nxt    = opRdData1;

        // Requester 1 wins when it asks alone, or when both ask and
        // requester 0 was the one served last.
        grantOne   = ipReq1 && (!ipReq0 || !lastServed);
        grantWrite = grantOne ? ipWrite1 : ipWrite0;

        case (state)
            IDLE: begin
                if (ipReq0 || ipReq1) begin
                    // Request fields are captured here only; the requester
                    // is free to change them from the next cycle on.
                    ownerNxt   = grantOne;
                    addressNxt = grantOne ? ipAddr1   : ipAddr0;
                    wrDataNxt  = grantOne ? ipWrData1 : ipWrData0;
                    if (grantWrite) begin
                        wrEnableNxt = 1'b1;
                        stateNxt    = WRITE;
                    end else begin
                        rdCntNxt = 4'd0;
                        stateNxt = READ;
                    end
                end
            end

            WRITE: begin
                // The strobe was high for this single cycle; the default
                // drops it on the next edge.
                ack0Nxt  = !owner;
                ack1Nxt  = owner;
                stateNxt = ACK;
            end

            READ: begin
                if (rdCnt == LAST_CNT) begin
                    if (owner) begin
                        rdData1Nxt = ipRdData;
                        ack1Nxt    = 1'b1;
                    end else begin
                        rdData0Nxt = ipRdData;
                        ack0Nxt    = 1'b1;
                    end
                    stateNxt = ACK;
                end else begin
                    rdCntNxt = rdCnt + 4'd1;
                end
            end

            ACK: begin
                // Requests seen during ACK are ignored; a held request is
                // re-arbitrated as a new transaction once back in IDLE.
                lastServedNxt = owner;
                stateNxt      = IDLE;
            end

            default: begin
                stateNxt = IDLE;
            end
        endcase

        busyNxt = (stateNxt != IDLE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            // An in-flight transaction is abandoned without an ack.
            // lastServed = 1 lets requester 0 win the first contention.
            state      <= IDLE;
            owner      <= 1'b0;
            lastServed <= 1'b1;
            rdCnt      <= 4'd0;
            opAddress  <= '0;
            opWrData   <= '0;
            opWrEnable <= 1'b0;
            opAck0     <= 1'b0;
            opAck1     <= 1'b0;
            opRdData0  <= '0;
            opRdData1  <= '0;
            opBusy     <= 1'b0;
        end else begin
            state      <= stateNxt;
            owner      <= ownerNxt;
            lastServed <= lastServedNxt;
            rdCnt      <= rdCntNxt;
            opAddress  <= addressNxt;
            opWrData   <= wrDataNxt;
            opWrEnable <= wrEnableNxt;
            opAck0     <= ack0Nxt;
            opAck1     <= ack1Nxt;
            opRdData0  <= rdData0Nxt;
            opRdData1  <= rdData1Nxt;
            opBusy     <= busyNxt;
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for reg_bus_arbiter. Three instances share one clock:
//   u[0] RD_LATENCY = 1  cycle-by-cycle vector table, contention, idle
//   u[1] RD_LATENCY = 3  read latency sequence
//   u[2] RD_LATENCY = 4  reset during a read
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_reg_bus_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst    [NI];
    logic          req0   [NI];
    logic          wr0    [NI];
    logic [AW-1:0] addr0  [NI];
    logic [DW-1:0] wd0    [NI];
    logic          ack0   [NI];
    logic [DW-1:0] rdo0   [NI];
    logic          req1   [NI];
    logic          wr1    [NI];
    logic [AW-1:0] addr1  [NI];
    logic [DW-1:0] wd1    [NI];
    logic          ack1   [NI];
    logic [DW-1:0] rdo1   [NI];
    logic [AW-1:0] busAddr[NI];
    logic [DW-1:0] busWd  [NI];
    logic          busWe  [NI];
    logic [DW-1:0] busRd  [NI];
    logic          busy   [NI];

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : u
            localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
            reg_bus_arbiter #(
                .ADDR_W    (AW),
                .DATA_W    (DW),
                .RD_LATENCY(LAT)
            ) dut (
                .ipClk     (clk),
                .ipReset   (rst[g]),
                .ipReq0    (req0[g]),
                .ipWrite0  (wr0[g]),
                .ipAddr0   (addr0[g]),
                .ipWrData0 (wd0[g]),
                .opAck0    (ack0[g]),
                .opRdData0 (rdo0[g]),
                .ipReq1    (req1[g]),
                .ipWrite1  (wr1[g]),
                .ipAddr1   (addr1[g]),
                .ipWrData1 (wd1[g]),
                .opAck1    (ack1[g]),
                .opRdData1 (rdo1[g]),
                .opAddress (busAddr[g]),
                .opWrData  (busWd[g]),
                .opWrEnable(busWe[g]),
                .ipRdData  (busRd[g]),
                .opBusy    (busy[g])
            );
        end
    endgenerate

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int i);
        req0[i] = 1'b0; wr0[i] = 1'b0; addr0[i] = '0; wd0[i] = '0;
        req1[i] = 1'b0; wr1[i] = 1'b0; addr1[i] = '0; wd1[i] = '0;
        busRd[i] = '0;
    endtask

    // Inputs applied before an edge and the outputs required after it.
    typedef struct {
        logic          rst;
        logic          r0;
        logic          w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1;
        logic          w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [DW-1:0] rd;
        logic          eAck0;
        logic          eAck1;
        logic          eWe;
        logic          eBusy;
        logic [AW-1:0] eAddr;
        logic [DW-1:0] eWd;
        logic [DW-1:0] eRd0;
        logic [DW-1:0] eRd1;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    initial begin
        logic [107:0] actBits;
        logic [107:0] expBits;

        // ---------------- vector table for u[0] (RD_LATENCY = 1) ----------------
        //           rst   r0    w0    a0     d0             r1    w1    a1     d1            rd               ack0  ack1  we    busy  addr   wd             rd0            rd1
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 32'h00000000};
        // single write from requester 0, request dropped right after grant
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'h02, 32'h000000A5, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 32'h000000A5, 32'h00000000, 32'h00000000};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h33, 32'h000000FF, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 32'h000000A5, 32'h00000000, 32'h00000000};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 32'h000000A5, 32'h00000000, 32'h00000000};
        // requester 1 read
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 8'h01, 32'h00000077, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 32'h00000077, 32'h00000000, 32'h00000000};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 32'h00000077, 32'h00000000, 32'hCAFEF00D};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 32'h00000077, 32'h00000000, 32'hCAFEF00D};
        // contention: 0 reads, 1 writes; last served was 1 so 0 wins
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h05, 32'h00000022, 1'b1, 1'b1, 8'h06, 32'h00000011, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 32'h00000022, 32'h00000000, 32'hCAFEF00D};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h05, 32'h00000022, 1'b1, 1'b1, 8'h06, 32'h00000011, 32'h0BADCAFE, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 32'h00000022, 32'h0BADCAFE, 32'hCAFEF00D};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h05, 32'h00000022, 1'b1, 1'b1, 8'h06, 32'h00000011, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 32'h00000022, 32'h0BADCAFE, 32'hCAFEF00D};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h05, 32'h00000022, 1'b1, 1'b1, 8'h06, 32'h00000011, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 8'h06, 32'h00000011, 32'h0BADCAFE, 32'hCAFEF00D};
        // write by 1 leaves both read-data outputs alone
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h05, 32'h00000022, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 8'h06, 32'h00000011, 32'h0BADCAFE, 32'hCAFEF00D};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h05, 32'h00000022, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h06, 32'h00000011, 32'h0BADCAFE, 32'hCAFEF00D};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h05, 32'h00000022, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 32'h00000022, 32'h0BADCAFE, 32'hCAFEF00D};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000055, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 32'h00000022, 32'h00000055, 32'hCAFEF00D};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 32'h00000022, 32'h00000055, 32'hCAFEF00D};
        // reset in the middle of a write: no ack, strobe not repeated
        vecs[16] = '{1'b0, 1'b1, 1'b1, 8'h09, 32'h00000099, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 8'h09, 32'h00000099, 32'h00000055, 32'hCAFEF00D};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h00000000, 32'h00000000, 32'h00000000};

        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1;
            quiet(i);
        end
        tick();

        for (int v = 0; v < NV; v++) begin
            rst[0]   = vecs[v].rst;
            req0[0]  = vecs[v].r0;  wr0[0] = vecs[v].w0; addr0[0] = vecs[v].a0; wd0[0] = vecs[v].d0;
            req1[0]  = vecs[v].r1;  wr1[0] = vecs[v].w1; addr1[0] = vecs[v].a1; wd1[0] = vecs[v].d1;
            busRd[0] = vecs[v].rd;
            tick();
            actBits = {ack0[0], ack1[0], busWe[0], busy[0], busAddr[0], busWd[0], rdo0[0], rdo1[0]};
            expBits = {vecs[v].eAck0, vecs[v].eAck1, vecs[v].eWe, vecs[v].eBusy,
                       vecs[v].eAddr, vecs[v].eWd, vecs[v].eRd0, vecs[v].eRd1};
            check($sformatf("vec%0d {ack0,ack1,we,busy,addr,wd,rd0,rd1}", v), 128'(actBits), 128'(expBits));
        end

        // ---------------- u[0]: both requesting reads from reset ----------------
        // Grants alternate 0,1,0,1 with acks three cycles apart.
        rst[0] = 1'b1;
        quiet(0);
        req0[0] = 1'b1; addr0[0] = 8'h10;
        req1[0] = 1'b1; addr1[0] = 8'h20;
        busRd[0] = 32'h00000123;
        tick();
        rst[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("contend cycle%0d {ack0,ack1}", k),
                  128'({ack0[0], ack1[0]}),
                  128'({(k == 1 || k == 7), (k == 4 || k == 10)}));
        end
        check("contend rd0", 128'(rdo0[0]), 128'(32'h00000123));
        check("contend rd1", 128'(rdo1[0]), 128'(32'h00000123));

        // ---------------- u[0]: idle for 50 cycles ----------------
        quiet(0);
        for (int k = 0; k < 4; k++) tick();
        for (int k = 0; k < 50; k++) begin
            tick();
            check($sformatf("idle cycle%0d {we,ack0,ack1,busy}", k),
                  128'({busWe[0], ack0[0], ack1[0], busy[0]}), 128'(4'b0000));
        end

        // ---------------- u[1]: RD_LATENCY = 3 ----------------
        rst[1] = 1'b0;
        req0[1] = 1'b1; wr0[1] = 1'b0; addr0[1] = 8'h03;
        busRd[1] = 32'hAAAA0000;
        tick();                               // grant requester 0 read
        req0[1] = 1'b0;
        for (int k = 0; k < 4; k++) tick();   // capture, ack, back to idle
        check("lat3 first read rd0", 128'(rdo0[1]), 128'(32'hAAAA0000));

        busRd[1] = 32'hDEADBEEF;
        req1[1] = 1'b1; wr1[1] = 1'b0; addr1[1] = 8'h01;
        tick();                               // grant edge
        check("lat3 grant addr", 128'(busAddr[1]), 128'(8'h01));
        req1[1] = 1'b0; addr1[1] = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 2) busRd[1] = 32'h12345678;
            check($sformatf("lat3 edge+%0d {ack0,ack1}", k),
                  128'({ack0[1], ack1[1]}), 128'({1'b0, (k == 3)}));
            if (k <= 3)
                check($sformatf("lat3 edge+%0d addr held", k), 128'(busAddr[1]), 128'(8'h01));
            if (k == 3) begin
                check("lat3 rd1", 128'(rdo1[1]), 128'(32'h12345678));
                check("lat3 rd0 untouched", 128'(rdo0[1]), 128'(32'hAAAA0000));
            end
        end

        // ---------------- u[2]: reset during a read, RD_LATENCY = 4 ----------------
        rst[2] = 1'b0;
        req0[2] = 1'b1; wr0[2] = 1'b1; addr0[2] = 8'h0A; wd0[2] = 32'h00000042;
        tick();                               // grant write, requester 0
        req0[2] = 1'b0;
        tick();                               // ack
        check("rst4 warm-up ack0", 128'(ack0[2]), 128'(1'b1));
        tick();                               // back to idle, last served = 0

        req1[2] = 1'b1; wr1[2] = 1'b0; addr1[2] = 8'h0B;
        tick();                               // grant read, requester 1
        check("rst4 grant addr", 128'(busAddr[2]), 128'(8'h0B));
        req1[2] = 1'b0;
        tick();                               // grant + 1
        rst[2] = 1'b1;
        tick();                               // reset applied at grant + 2
        check("rst4 after reset {ack0,ack1,we,busy,addr}",
              128'({ack0[2], ack1[2], busWe[2], busy[2], busAddr[2]}), 128'(12'h000));

        rst[2] = 1'b0;
        req0[2] = 1'b1; wr0[2] = 1'b0; addr0[2] = 8'h0C;
        req1[2] = 1'b1; wr1[2] = 1'b0; addr1[2] = 8'h0B;
        busRd[2] = 32'h0000BEEF;
        tick();
        check("rst4 first grant goes to 0", 128'(busAddr[2]), 128'(8'h0C));
        req0[2] = 1'b0;
        req1[2] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("rst4 edge+%0d {ack0,ack1}", k),
                  128'({ack0[2], ack1[2]}), 128'({(k == 4), 1'b0}));
        end
        check("rst4 rd0", 128'(rdo0[2]), 128'(32'h0000BEEF));
        check("rst4 rd1 cleared", 128'(rdo1[2]), 128'(32'h00000000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Cycle-level invariants over every instance.
    logic weLast[NI];
    initial for (int i = 0; i < NI; i++) weLast[i] = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (ack0[i] === 1'b1 && ack1[i] === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL u%0d both acks high: got 11, expected at most one", i);
            end
            if (busWe[i] === 1'b1 && weLast[i] === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL u%0d write strobe: got 2 consecutive cycles, expected 1", i);
            end
            weLast[i] <= busWe[i];
        end
    end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared register-bank bus (Address / WrData / WrEnable / RdData).
- Lets the UART packet controller (requester 0) and a local on-chip master such as a button/LED sequencer (requester 1) each run single read or write transactions against the register block.
- Uses round-robin arbitration, one transaction in flight at a time.
- Sits between the masters and the register block at the top level.

Parameters:
- ADDR_W, 8: register address width.
- DATA_W, 32: register data width.
- RD_LATENCY, 1: cycles from opAddress valid to ipRdData valid; legal range 1..15.

Ports:
- ipClk  in  1  system clock
- ipReset  in  1  synchronous reset, active-high
- ipReq0  in  1  requester 0 transaction request (level)
- ipWrite0  in  1  requester 0: 1 = write, 0 = read
- ipAddr0  in  ADDR_W  requester 0 address
- ipWrData0  in  DATA_W  requester 0 write data
- opAck0  out  1  requester 0 completion pulse
- opRdData0  out  DATA_W  requester 0 read data, valid with opAck0
- ipReq1, ipWrite1, ipAddr1, ipWrData1, opAck1, opRdData1: same as above, for requester 1
- opAddress  out  ADDR_W  to register block
- opWrData  out  DATA_W  to register block
- opWrEnable  out  1  to register block, one-cycle write strobe
- ipRdData  in  DATA_W  from register block
- opBusy  out  1  transaction in progress (state != IDLE)

Behaviour:
- All outputs are registered.
- Reset values: opAck0/1 = 0, opRdData0/1 = 0, opAddress = 0, opWrData = 0, opWrEnable = 0, opBusy = 0, state = IDLE, last-served = 1 (so requester 0 wins first).
- States: IDLE, WRITE, READ, ACK.
- IDLE:
  - If only one ipReqN is high, grant N.
  - If both are high, grant the one not last served.
  - On grant: latch winner index; load opAddress <= ipAddrN, opWrData <= ipWrDataN.
  - If ipWriteN: set opWrEnable <= 1 and go to WRITE. Otherwise clear the read counter and go to READ.
  - Request fields are sampled only in the grant cycle; the requester need not hold them afterwards.
- WRITE: exactly one cycle with opWrEnable = 1. Next edge: opWrEnable <= 0, opAckN <= 1, go to ACK.
- READ:
  - opAddress is held; the counter increments each cycle.
  - When counter == RD_LATENCY-1: opRdDataN <= ipRdData, opAckN <= 1, go to ACK.
- ACK:
  - opAckN is high for exactly this cycle. Update last-served <= N; clear opAckN; go to IDLE.
  - A request held high through ACK is treated as a new transaction and re-arbitrated in IDLE.
- Latency:
  - Write: grant edge to opAck high = 2 cycles.
  - Read: RD_LATENCY + 1 cycles.
  - Minimum spacing between back-to-back grants: 3 cycles (write, or read with RD_LATENCY = 1).
- Once granted, a transaction always completes; deasserting ipReqN mid-transaction is ignored.
- opRdDataN of the non-served requester is never modified. opRdData holds its last value until that requester's next read.
- A write never changes opRdDataN.
- opAddress and opWrData hold their last values in IDLE.
- opWrEnable is never high outside WRITE and never for more than one consecutive cycle.
- opAck0 and opAck1 are never high in the same cycle.
- Reset mid-transaction: at the next edge all outputs and state go to reset values. No ack is issued and the transaction is abandoned. A strobe already driven in the reset cycle is not repeated.
- opBusy = 1 in WRITE, READ and ACK.

Test Plan:
- Single write: ipReq0 = 1, ipWrite0 = 1, ipAddr0 = 0x02, ipWrData0 = 0x000000A5 for one cycle -> opWrEnable high for exactly 1 cycle with opAddress = 0x02, opWrData = 0xA5; opAck0 pulses 2 cycles after grant; opAck1 stays 0.
- Read, RD_LATENCY = 3: requester 1 reads 0x01 while the model drives ipRdData = 0x12345678 from 3 cycles after address -> opRdData1 = 0x12345678 with opAck1 at grant + 4; opRdData0 unchanged.
- Contention: both requests held high continuously from reset, reads -> grants alternate 0,1,0,1; each ack a single cycle; ack spacing 3 cycles at RD_LATENCY = 1.
- Request dropped mid-transaction: requester 0 write, ipReq0 low the cycle after grant -> write and opAck0 still occur.
- Reset mid-READ (RD_LATENCY = 4): assert ipReset at grant + 2 -> no opAck, opBusy = 0, opAddress = 0 next cycle; after release, requester 0 request is granted first.
- Idle check: no requests for 50 cycles -> opWrEnable, opAck0/1, opBusy all 0.
